// File: rtl/kitt_scan_multi.sv
// kitt_scan_multi: parametrised N-channel LED scanner core.
// Debounces the raw enable, divides the clock into scan steps, walks a head
// position through one of four patterns (bounce, wrap, dual centre-out, bar
// fill) and drives direct LED levels plus an optional PWM brightness trail.
// Optional feature macro: KITT_TRAIL_FADE_EN builds the per-channel trail
// levels and PWM counter; without it pwm_out mirrors led_out.
module kitt_scan_multi #(
    parameter int unsigned N_LEDS        = 8,
    parameter int unsigned PWM_BITS      = 4,
    parameter int unsigned STEP_DIV_FAST = 500000,
    parameter int unsigned STEP_DIV_SLOW = 1000000,
    parameter int unsigned DEB_CYCLES    = 10000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena_in,
    input  logic                      speed,
    input  logic [1:0]                mode,
    input  logic                      oinv,
    output logic [N_LEDS-1:0]         led_out,
    output logic [N_LEDS-1:0]         pwm_out,
    output logic [$clog2(N_LEDS)-1:0] pos,
    output logic                      step_tick
);

    localparam int unsigned POS_W = $clog2(N_LEDS);
    localparam int unsigned CNT_W = (STEP_DIV_SLOW > 1) ? $clog2(STEP_DIV_SLOW) : 1;
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DIV_FAST_M1 = CNT_W'(STEP_DIV_FAST - 1);
    localparam logic [CNT_W-1:0] DIV_SLOW_M1 = CNT_W'(STEP_DIV_SLOW - 1);
    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_LAST    = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] HALF_LAST   = POS_W'(N_LEDS / 2 - 1);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_WRAP   = 2'b01,
        MODE_DUAL   = 2'b10,
        MODE_BAR    = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Reject parameter sets the scan logic cannot represent.
    if (N_LEDS < 4 || N_LEDS > 32 || (N_LEDS % 2) != 0 || PWM_BITS < 1 ||
        STEP_DIV_FAST < 1 || STEP_DIV_SLOW < STEP_DIV_FAST || DEB_CYCLES < 1) begin : g_param_check
        $error("kitt_scan_multi: illegal parameter set");
    end

    // ------------------------------------------------------------------
    // Enable synchroniser and debounce
    // ------------------------------------------------------------------
    logic             sync1_q, sync2_q;
    logic             ena_db_q, ena_db_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // Two-flop synchroniser for the asynchronous raw enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ena_in;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new enable level only after it has disagreed for DEB_CYCLES in a row.
    always_comb begin
        deb_cnt_d = '0;
        ena_db_d  = ena_db_q;
        if (sync2_q != ena_db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                ena_db_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_db_q  <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            ena_db_q  <= ena_db_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Step timer
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] div_m1;

    // The divider follows speed every cycle, so a lowered threshold can fire at once.
    assign div_m1    = speed ? DIV_FAST_M1 : DIV_SLOW_M1;
    assign step_tick = ena_db_q && (step_cnt_q >= div_m1);

    // Count towards the step threshold; restart on a tick or while disabled.
    always_comb begin
        step_cnt_d = '0;
        if (ena_db_q && !step_tick) begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
        end
    end

    // Step counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: registered mode, direction, head position and LED pattern
    // ------------------------------------------------------------------
    mode_e             mode_q, mode_d, mode_in;
    dir_e              dir_q, dir_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  bounce_last;
    logic [N_LEDS-1:0] led_q, led_d;

    function automatic logic [N_LEDS-1:0] pattern(input mode_e m, input logic [POS_W-1:0] p);
        logic [N_LEDS-1:0] pat;
        int unsigned       pi;
        pat = '0;
        pi  = 32'(p);
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            case (m)
                MODE_DUAL: pat[i] = (i == pi) || (i == N_LEDS - 1 - pi);
                MODE_BAR:  pat[i] = (i <= pi);
                default:   pat[i] = (i == pi);
            endcase
        end
        return pat;
    endfunction

    // Next head position / direction / pattern; a mode change restarts at pos 0
    // and takes precedence over advancing the head.
    always_comb begin
        mode_d      = mode_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        led_d       = led_q;
        mode_in     = mode_e'(mode);
        bounce_last = (mode_q == MODE_DUAL) ? HALF_LAST : POS_LAST;
        if (!ena_db_q) begin
            dir_d = DIR_UP;
            pos_d = '0;
            led_d = '0;
        end else if (step_tick) begin
            if (mode_in != mode_q) begin
                mode_d = mode_in;
                dir_d  = DIR_UP;
                pos_d  = '0;
            end else begin
                case (mode_q)
                    MODE_BOUNCE, MODE_DUAL: begin
                        if (dir_q == DIR_UP) begin
                            if (pos_q >= bounce_last) begin
                                pos_d = pos_q - POS_W'(1);
                                dir_d = DIR_DOWN;
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                pos_d = POS_W'(1);
                                dir_d = DIR_UP;
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                    end
                    default: begin
                        dir_d = DIR_UP;
                        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                    end
                endcase
            end
            led_d = pattern(mode_d, pos_d);
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_BOUNCE;
            dir_q  <= DIR_UP;
            pos_q  <= '0;
            led_q  <= '0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            pos_q  <= pos_d;
            led_q  <= led_d;
        end
    end

    assign pos     = pos_q;
    assign led_out = led_q ^ {N_LEDS{oinv}};

    // ------------------------------------------------------------------
    // Brightness trail and PWM
    // ------------------------------------------------------------------
`ifdef KITT_TRAIL_FADE_EN
    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

    logic [N_LEDS-1:0][PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0]             pwm_cnt_q, pwm_cnt_d;
    logic [N_LEDS-1:0]               pwm_raw;

    // Lit channels reload full brightness each step; unlit ones halve.
    always_comb begin
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            level_d[i] = level_q[i];
            if (!ena_db_q) begin
                level_d[i] = '0;
            end else if (step_tick) begin
                level_d[i] = led_d[i] ? LVL_MAX : (level_q[i] >> 1);
            end
        end
    end

    // Free-running PWM phase 0..MAX-1, so MAX is always on and 0 always off.
    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == LVL_MAX - PWM_BITS'(1)) ? '0 : pwm_cnt_q + PWM_BITS'(1);
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            pwm_raw[i] = (level_q[i] > pwm_cnt_q);
        end
    end

    // Trail level and PWM phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            level_q   <= level_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm_out = pwm_raw ^ {N_LEDS{oinv}};
`else
    assign pwm_out = led_out;
`endif

endmodule
